// File: rtl/decoder_pkg.sv
// Shared types and widths for the registered 2-to-4 decoder.
// Imported by decoder2to4_comb and decoder2to4_hold.
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dec_state_t;

  localparam int DEC_IN_W  = 2;
  localparam int DEC_OUT_W = 4;

endpackage

// File: rtl/decoder2to4_comb.sv
// Purely combinational 2-to-4 one-hot decode.
// A[1] is the MSB; output is always exactly one-hot.
module decoder2to4_comb
  import decoder_pkg::*;
(
  input  logic [DEC_IN_W-1:0]  a,
  output logic [DEC_OUT_W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (1'b1)
      (a == 2'd0): y = 4'b0001;
      (a == 2'd1): y = 4'b0010;
      (a == 2'd2): y = 4'b0100;
      (a == 2'd3): y = 4'b1000;
      default:     y = '0;
    endcase
  end

endmodule

// File: rtl/decoder2to4_hold.sv
// Registered 2-to-4 decoder holding Y for HOLD_CYCLES, then pulsing done.
// Optional accepted-code counter enabled by macro DECODER_EVTCNT_EN.
module decoder2to4_hold
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DEC_IN_W-1:0]  A,
  output logic [DEC_OUT_W-1:0] Y,
  output logic                 busy,
  output logic                 done
`ifdef DECODER_EVTCNT_EN
  ,
  output logic [CNT_W-1:0]     evt_count
`endif
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES out of range 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("CNT_W must be at least 1");
  end

  dec_state_t state_q;
  dec_state_t state_d;
  logic [HW-1:0] cnt_q;
  logic [HW-1:0] cnt_d;
  logic [DEC_OUT_W-1:0] dec_y;
  logic [DEC_OUT_W-1:0] y_d;
  logic busy_d;
  logic done_d;
  logic accept;

  decoder2to4_comb u_comb (
    .a (A),
    .y (dec_y)
  );

  // Ready is forced low while reset is held.
  assign in_ready = (state_q == IDLE) & en & rst_n;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = Y;
    busy_d  = busy;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        y_d    = '0;
        busy_d = 1'b0;
        if (accept) begin
          y_d     = dec_y;
          cnt_d   = HOLD_INIT;
          busy_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!en) begin
          y_d     = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          y_d     = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        y_d     = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      Y       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      Y       <= y_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

`ifdef DECODER_EVTCNT_EN
  logic [CNT_W-1:0] evt_q;

  // Saturates rather than wraps; aborted holds still count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else if (accept && (evt_q != '1)) begin
      evt_q <= evt_q + 1'b1;
    end
  end

  assign evt_count = evt_q;
`endif

endmodule

// File: doc/decoder2to4_hold.md
# decoder2to4_hold

Registered 2-to-4 decoder with hold timing: the receive-side counterpart of the 4-to-2 encoder path. It accepts a 2-bit code over a valid/ready handshake and drives the matching one-hot line on `Y` for a programmable number of cycles. It then releases `Y` to zero and pulses `done`. It sits downstream of the encoder in the combinational-circuit set, turning encoded codes back into timed select strobes.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles `Y` stays asserted per accepted code; legal range 1..255.
- `CNT_W`, default 8: width of the event counter (only used with `DECODER_EVTCNT_EN`).

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  block enable; low aborts any active hold.
- `in_valid`  input  1  code `A` is presented.
- `in_ready`  output  1  block can accept; combinational, `(state==IDLE) & en`.
- `A`  input  2  encoded code; `A[1]` is the MSB.
- `Y`  output  4  registered one-hot decode, `Y[i]=1` iff code `i`; all zero when idle.
- `busy`  output  1  registered; high while in HOLD.
- `done`  output  1  registered; one-cycle pulse on normal hold completion.
- `evt_count`  output  `CNT_W`  accepted-code count; present only with `DECODER_EVTCNT_EN`.

## Operation
- FSM has two states, IDLE and HOLD, plus a hold counter of width `$clog2(HOLD_CYCLES+1)`.
- **IDLE:**
  - `Y=0`, `busy=0`.
  - On `in_valid & in_ready` (accept): `Y <= 1<<A`, counter `<= HOLD_CYCLES-1`, `busy <= 1`, go to HOLD.
  - Without an accept, the state is unchanged.
- **HOLD:**
  - `in_ready=0`; `in_valid` and `A` are ignored, so a new code cannot overwrite the current one.
  - Counter != 0: decrement, hold `Y`.
  - Counter == 0 with `en=1`: `Y <= 0`, `busy <= 0`, `done <= 1`, go to IDLE.
- **Abort:** `en=0` in HOLD gives `Y <= 0`, `busy <= 0`, `done` stays 0, go to IDLE. This applies even on the final hold cycle.
- `done` is high for exactly one cycle per completed hold; otherwise 0.
- `Y` is always either zero or exactly one-hot; it is never multi-hot.

## Timing
- **Reset** (asynchronous assert, synchronous release):
  - State IDLE, counter 0.
  - `Y=4'b0000`, `busy=0`, `done=0`, `evt_count=0`.
  - `in_ready` follows `en` once out of reset and is 0 while `rst_n=0`.
- **Latency:** accept at edge k means `Y` is valid after edge k. It stays valid for exactly `HOLD_CYCLES` cycles and clears at edge k+`HOLD_CYCLES`, where `done` rises.
- **Back-to-back codes:**
  - The `done` cycle is IDLE, so `in_ready` is high and a new code may be accepted at edge k+`HOLD_CYCLES`+1.
  - This guarantees at least one cycle of `Y=0` between codes.
  - Maximum throughput is one code per `HOLD_CYCLES+1` cycles.
- **`HOLD_CYCLES=1`:** `Y` is high for one cycle, then `done`; a code is accepted every 2 cycles.
- **Reset mid-hold:** `Y` clears immediately (asynchronously) and no `done` is issued.

## Configuration
- Macro `DECODER_EVTCNT_EN`.
- **Defined:**
  - `evt_count` port exists.
  - It increments by 1 on every accept and saturates at `2^CNT_W-1`; it never wraps.
  - Aborted holds still count.
- **Undefined:** the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `decoder_pkg`:
  - state enum `dec_state_t` {IDLE, HOLD};
  - localparam `DEC_IN_W=2`;
  - localparam `DEC_OUT_W=4`.
- One sub-module, `decoder2to4_comb`: purely combinational `A` to one-hot. It is instantiated once, and its output is registered into `Y` on accept.

## Test plan
- **Reset:** assert `rst_n=0` mid-hold with `A=2'b11` active -> `Y=0000`, `busy=0`, `done=0` immediately; `in_ready=1` after release with `en=1`.
- **All codes:** `HOLD_CYCLES=4`, accept `A`=0,1,2,3 sequentially -> `Y`=0001, 0010, 0100, 1000. Each is held exactly 4 cycles, followed by one `done` pulse with `Y=0`.
- **Ignore during HOLD:** accept `A=1`, then drive `A=3` with `in_valid=1` throughout -> `in_ready=0`, `Y` stays 0010 for 4 cycles. `A=3` is accepted on the `done` cycle, giving `Y=1000` one cycle later.
- **Abort:** accept `A=2`, drop `en` on hold cycle 2 -> `Y=0000` next cycle, no `done`, `busy=0`.
- **Minimum hold:** `HOLD_CYCLES=1`, `in_valid` held high with `A=0` -> `Y` alternates 0001/0000 each cycle and `done` pulses every 2nd cycle.
- **Counter** (`DECODER_EVTCNT_EN`, `CNT_W=2`): 5 accepts -> `evt_count` reads 1, 2, 3, 3, 3.
